mmio_responder: RTL and testbench
=================================

Name: mmio_responder

Overview:
- Memory-mapped I/O responder on the CPU data-memory bus; it is the target side of the CPU's `mem_cmd`/`mem_addr` initiator.
- Owns the board I/O:
  - LED register
  - 4-digit hex display register
  - synchronized switch input
  - 16-bit cycle counter with run control
- Sits beside the RAM in the top level.
- Its read data is muxed with RAM read data using `rd_hit`.

Parameters:
- `ADDR_LED`, 9'h100, LED register word address (R/W)
- `ADDR_HEX`, 9'h120, hex display data word address (R/W)
- `ADDR_HEXCTL`, 9'h121, hex control address; bit0 = display enable (R/W)
- `ADDR_CNT`, 9'h130, cycle counter value address (R/W; a write loads the counter)
- `ADDR_CNTCTL`, 9'h131, counter control address; bit0 = run (R/W)
- `ADDR_SW`, 9'h140, switch input address (read-only)

Ports:
- `clk` input 1: single system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `mem_cmd` input 2: bus command; MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10; 2'b11 is treated as MNONE.
- `mem_addr` input 9: word address.
- `write_data` input 16: write data.
- `read_data` output 16: registered read data.
- `rd_hit` output 1: registered; high for exactly one cycle after a mapped MREAD.
- `SW` input 10: raw board switches, asynchronous.
- `LEDR` output 8: LED register bits [7:0].
- `HEX0`, `HEX1`, `HEX2`, `HEX3` output 7 each: active-low seven-segment drives; `HEX0` shows the least significant nibble.

Behaviour:

Reset (at a clk edge with `reset`=1):
- `led_q`=0, `hex_q`=0, `hex_en`=0, `cnt`=0, `run`=0.
- Switch sync flops = 0, `read_data`=0, `rd_hit`=0.
- Therefore `LEDR`=8'h00 and `HEX0`–`HEX3`=7'h7F (all segments off).
- Reset overrides any simultaneous bus command; a read issued in the reset cycle produces no `rd_hit`.

Writes (`mem_cmd`=MWRITE and address mapped):
- Register updates at that edge and is visible on outputs the next cycle.
- `ADDR_LED` ← `write_data[7:0]`.
- `ADDR_HEX` ← `write_data[15:0]`.
- `ADDR_HEXCTL` ← `write_data[0]`.
- `ADDR_CNT` ← `write_data`.
- `ADDR_CNTCTL` ← `write_data[0]`.
- Writes to `ADDR_SW` or unmapped addresses are ignored with no side effects.

Reads (`mem_cmd`=MREAD):
- Latency is exactly 1 cycle, matching RAM.
- For a read presented in cycle N:
  - `read_data`/`rd_hit` are valid in cycle N+1.
  - Both are held until the next edge, then `rd_hit` returns to 0.
  - `read_data` holds its last value when `rd_hit`=0.
- Read values, zero-extended to 16 bits:
  - LED: {8'b0, `led_q`}
  - HEX: `hex_q`
  - HEXCTL: {15'b0, `hex_en`}
  - CNT: `cnt` value before that edge's increment
  - CNTCTL: {15'b0, `run`}
  - SW: {6'b0, `sw_sync`}
- Unmapped address: `rd_hit`=0 and `read_data` unchanged.
- Back-to-back reads on consecutive cycles are fully supported; each returns its own data one cycle later.
- Write-then-read to the same register on consecutive cycles returns the new value.

Switch path:
- Two-flop synchronizer on all 10 bits.
- A `SW` change is readable no earlier than the second edge after it settles.

Counter:
- Increments by 1 each cycle while `run`=1.
- Wraps 16'hFFFF→16'h0000 with no flag.
- If a write to `ADDR_CNT` coincides with an increment, the write wins.
- A write clearing `run` stops the counter at that edge, so `cnt` does not increment on that edge.

Display:
- When `hex_en`=1, each `HEXk` = `seg7(hex_q[4k+3:4k])`, digits 0–F, active-low.
  - Examples: 0→7'b1000000, 1→7'b1111001, A→7'b0001000, F→7'b0001110.
- When `hex_en`=0, all digits are 7'h7F.
- Outputs are combinational from the registers, so there is no extra latency.

Decomposition:
- Package `mmio_pkg`:
  - `mem_cmd_t` enum (MNONE, MREAD, MWRITE)
  - default address constants
  - `SEG_OFF`=7'h7F
- Sub-module `seg7_decoder`: 4-bit in, 7-bit active-low out; instantiated four times.
- Everything else lives in `mmio_responder`.

Test Plan:
- Reset held 2 cycles with random `mem_cmd` → `LEDR`=0, `HEX0`–`HEX3`=7'h7F, `rd_hit`=0, `read_data`=0; read of `ADDR_CNT` after reset returns 0.
- Write 16'h00A5 to `ADDR_LED`, then MREAD `ADDR_LED` the next cycle → `LEDR`=8'hA5 one cycle after the write; `rd_hit`=1 one cycle after the read with `read_data`=16'h00A5; `rd_hit` low the following cycle.
- Write 16'h1A2F to `ADDR_HEX` with `hex_en`=0 → `HEX*` stay 7'h7F. Then write 1 to `ADDR_HEXCTL` → `HEX3`..`HEX0` = 1111001, 0001000, 0100100, 0001110.
- Set `SW`=10'h2B5, then read `ADDR_SW` at 1 and 3 cycles later → first read returns the old value, second returns 16'h02B5.
- Write 16'hFFFE to `ADDR_CNT`, write 1 to `ADDR_CNTCTL`, wait 3 cycles, then read → value has wrapped through 0 (FFFE→FFFF→0000→0001 sequence checked). A concurrent `ADDR_CNT` write of 16'h0005 overrides the increment.
- MREAD 9'h0FF (unmapped) and MWRITE 16'hFFFF to `ADDR_SW` → `rd_hit`=0, `read_data` unchanged, all register readbacks unchanged. Reset asserted the cycle after an MREAD → `rd_hit`=0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO responder slice.
//   mem_cmd_t      : CPU data-bus command encoding (2'b11 behaves as MNONE)
//   ADDR_*_DFLT    : default word addresses of the mapped registers
//   SEG_OFF        : active-low seven-segment pattern with every segment dark
package mmio_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_t;

  localparam logic [8:0] ADDR_LED_DFLT    = 9'h100;
  localparam logic [8:0] ADDR_HEX_DFLT    = 9'h120;
  localparam logic [8:0] ADDR_HEXCTL_DFLT = 9'h121;
  localparam logic [8:0] ADDR_CNT_DFLT    = 9'h130;
  localparam logic [8:0] ADDR_CNTCTL_DFLT = 9'h131;
  localparam logic [8:0] ADDR_SW_DFLT     = 9'h140;

  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg7_decoder.sv
// Hex digit to active-low seven-segment decoder.
//   digit : 4-bit value 0..F
//   seg   : segments {g,f,e,d,c,b,a}, 0 = lit
module seg7_decoder (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped I/O target on the CPU data bus, sitting beside the RAM.
// Owns the LED register, a 4-digit hex display, synchronized switches and a
// 16-bit free-running cycle counter. Reads have one cycle of latency, like RAM;
// rd_hit steers the top-level read mux toward this block.
//   clk, reset          : system clock, synchronous active-high reset
//   mem_cmd, mem_addr   : bus command and word address
//   write_data          : bus write data
//   read_data, rd_hit   : registered read response (valid the cycle after MREAD)
//   SW                  : raw asynchronous board switches
//   LEDR                : LED register
//   HEX0..HEX3          : active-low seven-segment digits, HEX0 = low nibble
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [8:0] ADDR_LED    = ADDR_LED_DFLT,
  parameter logic [8:0] ADDR_HEX    = ADDR_HEX_DFLT,
  parameter logic [8:0] ADDR_HEXCTL = ADDR_HEXCTL_DFLT,
  parameter logic [8:0] ADDR_CNT    = ADDR_CNT_DFLT,
  parameter logic [8:0] ADDR_CNTCTL = ADDR_CNTCTL_DFLT,
  parameter logic [8:0] ADDR_SW     = ADDR_SW_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        rd_hit,
  input  logic [9:0]  SW,
  output logic [7:0]  LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  logic [7:0]  led_q;
  logic [15:0] hex_q;
  logic        hex_en;
  logic [15:0] cnt;
  logic        run;
  logic [9:0]  sw_meta;
  logic [9:0]  sw_sync;

  logic        is_rd;
  logic        is_wr;
  logic        rd_mapped;
  logic [15:0] rd_val;
  logic        run_next;
  logic [6:0]  seg [4];

  assign is_rd = (mem_cmd == MREAD);
  assign is_wr = (mem_cmd == MWRITE);

  always_comb begin
    rd_mapped = 1'b1;
    rd_val    = 16'h0000;
    case (mem_addr)
      ADDR_LED:    rd_val = {8'h00, led_q};
      ADDR_HEX:    rd_val = hex_q;
      ADDR_HEXCTL: rd_val = {15'h0000, hex_en};
      ADDR_CNT:    rd_val = cnt;
      ADDR_CNTCTL: rd_val = {15'h0000, run};
      ADDR_SW:     rd_val = {6'h00, sw_sync};
      default:     rd_mapped = 1'b0;
    endcase
  end

  // The counter only advances when run is set both before and after this edge,
  // so a write that clears run freezes cnt at the same edge.
  assign run_next = (is_wr && mem_addr == ADDR_CNTCTL) ? write_data[0] : run;

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= 8'h00;
      hex_q     <= 16'h0000;
      hex_en    <= 1'b0;
      cnt       <= 16'h0000;
      run       <= 1'b0;
      sw_meta   <= 10'h000;
      sw_sync   <= 10'h000;
      read_data <= 16'h0000;
      rd_hit    <= 1'b0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
      run     <= run_next;

      if (is_wr && mem_addr == ADDR_LED)    led_q  <= write_data[7:0];
      if (is_wr && mem_addr == ADDR_HEX)    hex_q  <= write_data;
      if (is_wr && mem_addr == ADDR_HEXCTL) hex_en <= write_data[0];

      if (is_wr && mem_addr == ADDR_CNT)
        cnt <= write_data;
      else if (run && run_next)
        cnt <= cnt + 16'd1;

      rd_hit <= is_rd && rd_mapped;
      if (is_rd && rd_mapped) read_data <= rd_val;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_digit
    seg7_decoder u_seg (
      .digit (hex_q[4*k +: 4]),
      .seg   (seg[k])
    );
  end

  assign LEDR = led_q;
  assign HEX0 = hex_en ? seg[0] : SEG_OFF;
  assign HEX1 = hex_en ? seg[1] : SEG_OFF;
  assign HEX2 = hex_en ? seg[2] : SEG_OFF;
  assign HEX3 = hex_en ? seg[3] : SEG_OFF;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder with hand-computed expectations.
module tb_mmio_responder;

  localparam logic [8:0] A_LED    = 9'h100;
  localparam logic [8:0] A_HEX    = 9'h120;
  localparam logic [8:0] A_HEXCTL = 9'h121;
  localparam logic [8:0] A_CNT    = 9'h130;
  localparam logic [8:0] A_CNTCTL = 9'h131;
  localparam logic [8:0] A_SW     = 9'h140;
  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_READ  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        rd_hit;
  logic [9:0]  SW;
  logic [7:0]  LEDR;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  int n_total = 0;
  int n_bad   = 0;

  mmio_responder dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .rd_hit     (rd_hit),
    .SW         (SW),
    .LEDR       (LEDR),
    .HEX0       (HEX0),
    .HEX1       (HEX1),
    .HEX2       (HEX2),
    .HEX3       (HEX3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one bus cycle, then advance past the next rising edge.
  task automatic bus(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = data;
    @(posedge clk);
    #1;
    mem_cmd    = C_NONE;
  endtask

  task automatic idle();
    bus(C_NONE, 9'h000, 16'h0000);
  endtask

  initial begin
    reset = 1'b1; mem_cmd = C_NONE; mem_addr = 9'h000; write_data = 16'h0000; SW = 10'h000;
    #1;

    // reset held two cycles with random commands aimed at LED
    for (int i = 0; i < 2; i++) bus(2'($urandom_range(0, 3)), A_LED, 16'hFFFF);
    check("rst_ledr", {8'h00, LEDR}, 16'h0000);
    check("rst_hex0", {9'h0, HEX0}, 16'h007F);
    check("rst_hex3", {9'h0, HEX3}, 16'h007F);
    check("rst_rd_hit", {15'h0, rd_hit}, 16'h0000);
    check("rst_read_data", read_data, 16'h0000);
    reset = 1'b0;
    bus(C_READ, A_CNT, 16'h0);
    check("rst_cnt_hit", {15'h0, rd_hit}, 16'h0001);
    check("rst_cnt_val", read_data, 16'h0000);

    // LED write then immediate read-back
    bus(C_WRITE, A_LED, 16'h00A5);
    check("led_out", {8'h00, LEDR}, 16'h00A5);
    bus(C_READ, A_LED, 16'h0);
    check("led_rd_hit", {15'h0, rd_hit}, 16'h0001);
    check("led_rd_val", read_data, 16'h00A5);
    idle();
    check("led_rd_hit_drop", {15'h0, rd_hit}, 16'h0000);
    check("led_rd_hold", read_data, 16'h00A5);

    // hex display, disabled then enabled
    bus(C_WRITE, A_HEX, 16'h1A2F);
    check("hex_off0", {9'h0, HEX0}, 16'h007F);
    check("hex_off2", {9'h0, HEX2}, 16'h007F);
    bus(C_WRITE, A_HEXCTL, 16'h0001);
    check("hex3", {9'h0, HEX3}, {9'h0, 7'b1111001});
    check("hex2", {9'h0, HEX2}, {9'h0, 7'b0001000});
    check("hex1", {9'h0, HEX1}, {9'h0, 7'b0100100});
    check("hex0", {9'h0, HEX0}, {9'h0, 7'b0001110});
    bus(C_READ, A_HEX, 16'h0);
    check("hex_rd", read_data, 16'h1A2F);
    bus(C_READ, A_HEXCTL, 16'h0);
    check("hexctl_rd", read_data, 16'h0001);

    // switch synchronizer latency
    SW = 10'h2B5;
    idle();
    bus(C_READ, A_SW, 16'h0);
    check("sw_old", read_data, 16'h0000);
    idle();
    bus(C_READ, A_SW, 16'h0);
    check("sw_new", read_data, 16'h02B5);

    // counter wrap, write priority, stop on run clear
    bus(C_WRITE, A_CNT, 16'hFFFE);
    bus(C_WRITE, A_CNTCTL, 16'h0001);
    bus(C_READ, A_CNT, 16'h0);
    check("cnt_fffe", read_data, 16'hFFFE);
    bus(C_READ, A_CNT, 16'h0);
    check("cnt_ffff", read_data, 16'hFFFF);
    bus(C_READ, A_CNT, 16'h0);
    check("cnt_0000", read_data, 16'h0000);
    bus(C_READ, A_CNT, 16'h0);
    check("cnt_0001", read_data, 16'h0001);
    bus(C_WRITE, A_CNT, 16'h0005);
    bus(C_READ, A_CNT, 16'h0);
    check("cnt_wr_wins", read_data, 16'h0005);
    bus(C_READ, A_CNTCTL, 16'h0);
    check("cntctl_rd", read_data, 16'h0001);
    bus(C_WRITE, A_CNTCTL, 16'h0000);
    bus(C_READ, A_CNT, 16'h0);
    check("cnt_stop", read_data, 16'h0007);
    bus(C_READ, A_CNT, 16'h0);
    check("cnt_stopped", read_data, 16'h0007);

    // unmapped read and write to read-only switch address
    bus(C_READ, A_LED, 16'h0);
    check("pre_unmapped", read_data, 16'h00A5);
    bus(C_READ, 9'h0FF, 16'h0);
    check("unmapped_hit", {15'h0, rd_hit}, 16'h0000);
    check("unmapped_hold", read_data, 16'h00A5);
    bus(C_WRITE, A_SW, 16'hFFFF);
    bus(C_READ, A_SW, 16'h0);
    check("sw_ro", read_data, 16'h02B5);
    bus(C_READ, A_LED, 16'h0);
    check("led_after_sw_wr", read_data, 16'h00A5);
    bus(C_READ, A_HEX, 16'h0);
    check("hex_after_sw_wr", read_data, 16'h1A2F);
    bus(C_READ, A_CNT, 16'h0);
    check("cnt_after_sw_wr", read_data, 16'h0007);
    bus(2'b11, A_LED, 16'h0033);
    check("cmd11_nohit", {15'h0, rd_hit}, 16'h0000);
    check("cmd11_nowrite", {8'h00, LEDR}, 16'h00A5);

    // reset interacting with reads
    bus(C_READ, A_LED, 16'h0);
    check("pre_rst_hit", {15'h0, rd_hit}, 16'h0001);
    reset = 1'b1;
    bus(C_READ, A_LED, 16'h0);
    check("rst_read_hit", {15'h0, rd_hit}, 16'h0000);
    check("rst_read_data2", read_data, 16'h0000);
    check("rst_ledr2", {8'h00, LEDR}, 16'h0000);
    reset = 1'b0;
    bus(C_READ, A_SW, 16'h0);
    check("sw_resync", read_data, 16'h0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
